// File: rtl/param_sync_cntr.sv
// param_sync_cntr: parametrised synchronous modulo-N up/down counter.
// Clear has priority over load, load over count enable. The count wraps or
// saturates at the range ends. A terminal-count flag and a registered
// boundary-event pulse are provided for chaining into dividers and slot
// counters.
module param_sync_cntr #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MODULUS  = 256,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  // Largest legal count value; every state the counter can enter is <= this.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic             at_max;
  logic             at_zero;
  logic             boundary;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] load_q;

  // Next-count and boundary decode from the current count and direction.
  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    at_max   = (q == MAX_VAL);
    at_zero  = (q == '0);
    boundary = up_dn ? at_max : at_zero;
    q_step   = q;
    if (up_dn) begin
      if (!at_max) begin
        q_step = q + WIDTH'(1);
      end else if (!SATURATE) begin
        q_step = '0;
      end
    end else begin
      if (!at_zero) begin
        q_step = q - WIDTH'(1);
      end else if (!SATURATE) begin
        q_step = MAX_VAL;
      end
    end
    // Out-of-range load values are clamped so q never leaves 0..MODULUS-1.
    load_q = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  end

  // Terminal count depends only on q and direction, not on en.
  assign tc = boundary;

  // Count register and boundary-event pulse; clear > load > en.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      q   <= load_q;
      ovf <= 1'b0;
    end else if (en) begin
      q   <= q_step;
      ovf <= boundary;
    end else begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: doc/param_sync_cntr.md
Name: param_sync_cntr

Overview:
- Parametrised synchronous modulo-N up/down counter; successor to the fixed 3-bit T-flip-flop synchronous counter.
- Adds generic width and modulus, count direction, count enable, parallel load, wrap or saturate mode, terminal-count and overflow flags.
- Used as a general timing/sequencing primitive, e.g. baud dividers and frame/slot counters, in later sequential blocks.

Parameters:
- WIDTH, 8, counter width in bits (>=1).
- MODULUS, 256, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  synchronous active-high reset.
- en  in  1  count enable; counter steps one per clk while high.
- up_dn  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- q  out  WIDTH  registered count value.
- tc  out  1  terminal count, combinational from q and up_dn.
- ovf  out  1  registered one-cycle boundary-event pulse.

Behaviour:
- Interface: single clock clk; reset is synchronous, active-high, port name clear.
- All state updates on rising clk. Priority: clear > load > en. Inputs are sampled at the edge; q changes one edge after the request.
- clear=1 at an edge: q <= 0, ovf <= 0, regardless of load/en. Mid-count clear gives q=0 at the next edge and discards any pending step.
- load=1 (clear=0): q <= load_val if load_val <= MODULUS-1, else q <= MODULUS-1 (clamped). ovf <= 0. en is ignored that cycle.
- en=1, load=0, clear=0:
  - up_dn=1, q < MODULUS-1: q <= q+1.
  - up_dn=0, q > 0: q <= q-1.
  - up_dn=1, q == MODULUS-1: SATURATE=0 gives q <= 0; SATURATE=1 holds q.
  - up_dn=0, q == 0: SATURATE=0 gives q <= MODULUS-1; SATURATE=1 holds q.
- ovf: set to 1 at the edge a boundary step occurs (wrap or saturation-hold attempt, either direction). Cleared at the next edge unless another boundary step occurs there, so continuous saturation with en=1 keeps ovf high.
- ovf <= 0 whenever en=0, load=1 or clear=1.
- en=0 (no load/clear): q holds, ovf <= 0.
- tc = (up_dn && q == MODULUS-1) || (!up_dn && q == 0). tc does not depend on en and follows up_dn combinationally.
- Arithmetic is within WIDTH bits. With MODULUS = 2**WIDTH, wrap is natural binary overflow. With non-power-of-two MODULUS, q never leaves 0..MODULUS-1.
- Direction change takes effect at the first edge where the new up_dn is sampled; there is no dead cycle.
- No X on outputs after the first clear edge. Outputs are undefined before the first clear.

Test Plan:
- WIDTH=3, MODULUS=8, SATURATE=0: clear 1 cycle, then en=1, up_dn=1 for 10 cycles -> q = 0,1,..,7,0,1. ovf high only in the cycle q becomes 0. tc high while q=7.
- WIDTH=4, MODULUS=10, SATURATE=0: up_dn=0 from q=0 -> q = 9,8,..,0,9. ovf pulses on the 0->9 transition. q never reaches 10..15.
- WIDTH=4, MODULUS=10, SATURATE=1: load_val=8, then count up 4 cycles -> q = 8,9,9,9. ovf = 0,1,1. Then up_dn=0 -> q = 8, ovf = 0.
- Priority: same edge clear=1, load=1, load_val=5, en=1 -> q=0. Next edge load=1, en=1 -> q=5 (no step). load_val=12 with MODULUS=10 -> q=9.
- Enable and direction: en toggled 1,0,1 -> q advances only on en=1 edges. up_dn flipped at q=4 -> next q=3. tc tracks up_dn immediately at q=0 and q=MODULUS-1.
- Default parameters: free run 300 cycles from clear -> q == 300 mod 256 = 44. Exactly one ovf pulse, at cycle 256.
